// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types and field extraction for the serial instruction decoder.
// Optional IDLI_SDC_ERR_EN adds an err flag to op_t for the reserved 0001/0010/0011 opcode groups.
package idli_pkg;

  typedef logic [1:0] preg_t;
  typedef logic [2:0] greg_t;

  localparam preg_t PREG_PT = 2'b11;

  typedef enum logic {
    ST_INSN,
    ST_IMM
  } sdc_state_t;

  typedef struct packed {
    logic [4:0]  opc;
    preg_t       p;
    preg_t       q;
    greg_t       a;
    greg_t       b;
    greg_t       c;
    logic        imm;
    logic [15:0] imm_val;
`ifdef IDLI_SDC_ERR_EN
    logic        err;
`endif
  } op_t;

  function automatic op_t sdc_extract(input logic [15:0] w);
    op_t op;
    op     = '0;
    op.opc = w[15:11];
    // Opcode group 0000 carries no predicate; it always executes under PT.
    op.p   = (w[15:12] == 4'b0000) ? PREG_PT : w[10:9];
    op.a   = {w[8], w[7:6]};
    op.q   = w[7:6];
    op.b   = w[5:3];
    op.c   = w[2:0];
    op.imm = &w[2:0];
`ifdef IDLI_SDC_ERR_EN
    op.err = (w[15:12] == 4'b0001) || (w[15:12] == 4'b0010) || (w[15:12] == 4'b0011);
    if (op.err) op.imm = 1'b0;
`endif
    return op;
  endfunction

endpackage

// File: rtl/idli_serial_decode_m_deser.sv
// rtl/idli_serial_decode_m_deser.sv - LANES-wide to 16b deserialiser with beat counter and last-beat flag.
module idli_sdc_deser_m
  import idli_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [LANES-1:0] i_beat,
  input  logic             i_shift,
  output logic [15:0]      o_word,
  output logic             o_last
);

  localparam int BEATS = 16 / LANES;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

  // Only the history is stored; the current beat completes the word combinationally
  // so the decode can be registered in the same cycle as the final beat.
  logic [15-LANES:0] sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  assign o_word = {sr_q, i_beat};
  assign o_last = (cnt_q == CNT_LAST);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (i_shift) begin
      sr_d  = o_word[15-LANES:0];
      cnt_d = o_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/idli_serial_decode_m.sv
// rtl/idli_serial_decode_m.sv - serial instruction decoder: assembles insn (+imm) words and publishes one op.
// Build option IDLI_SDC_ERR_EN: flag reserved encodings as err and suppress their immediate.
module idli_serial_decode_m
  import idli_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic             i_sdc_gck,
  input  logic             i_sdc_rst,
  input  logic [LANES-1:0] i_sdc_enc,
  input  logic             i_sdc_enc_vld,
  output logic             o_sdc_enc_rdy,
  output op_t              o_sdc_op,
  output logic             o_sdc_op_vld,
  input  logic             i_sdc_op_rdy
);

  sdc_state_t  state_q, state_d;
  op_t         op_q, op_d;
  op_t         pend_q, pend_d;
  op_t         dec;
  logic        vld_q, vld_d;
  logic [15:0] word;
  logic        last;
  logic        final_beat;
  logic        fire;

  idli_sdc_deser_m #(.LANES(LANES)) u_deser (
    .i_clk   (i_sdc_gck),
    .i_rst   (i_sdc_rst),
    .i_beat  (i_sdc_enc),
    .i_shift (fire),
    .o_word  (word),
    .o_last  (last)
  );

  assign dec = sdc_extract(word);

  // Only the beat that would publish waits for a free output slot; all others overlap.
  assign final_beat    = last && ((state_q == ST_IMM) || !dec.imm);
  assign o_sdc_enc_rdy = final_beat ? (!vld_q || i_sdc_op_rdy) : 1'b1;
  assign fire          = i_sdc_enc_vld && o_sdc_enc_rdy;

  assign o_sdc_op     = op_q;
  assign o_sdc_op_vld = vld_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    op_d    = op_q;
    vld_d   = vld_q && !i_sdc_op_rdy;
    if (fire && last) begin
      if (state_q == ST_INSN) begin
        if (dec.imm) begin
          pend_d  = dec;
          state_d = ST_IMM;
        end else begin
          op_d  = dec;
          vld_d = 1'b1;
        end
      end else begin
        op_d         = pend_q;
        op_d.imm_val = word;
        vld_d        = 1'b1;
        state_d      = ST_INSN;
      end
    end
  end

  always_ff @(posedge i_sdc_gck) begin
    if (i_sdc_rst) begin
      state_q <= ST_INSN;
      op_q    <= '0;
      pend_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_idli_serial_decode_m.sv
// tb/tb_idli_serial_decode_m.sv - directed bench for idli_serial_decode_m at LANES 4, 8 and 1.
module tb_idli_serial_decode_m;
  import idli_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_rdy;
  logic [3:0] enc4;
  logic [7:0] enc8;
  logic [0:0] enc1;
  logic       ev4, ev8, ev1;
  logic       rdy4, rdy8, rdy1;
  op_t        op4, op8, op1;
  logic       ov4, ov8, ov1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idli_serial_decode_m #(.LANES(4)) u_dut4 (
    .i_sdc_gck(clk), .i_sdc_rst(rst), .i_sdc_enc(enc4), .i_sdc_enc_vld(ev4),
    .o_sdc_enc_rdy(rdy4), .o_sdc_op(op4), .o_sdc_op_vld(ov4), .i_sdc_op_rdy(op_rdy));
  idli_serial_decode_m #(.LANES(8)) u_dut8 (
    .i_sdc_gck(clk), .i_sdc_rst(rst), .i_sdc_enc(enc8), .i_sdc_enc_vld(ev8),
    .o_sdc_enc_rdy(rdy8), .o_sdc_op(op8), .o_sdc_op_vld(ov8), .i_sdc_op_rdy(op_rdy));
  idli_serial_decode_m #(.LANES(1)) u_dut1 (
    .i_sdc_gck(clk), .i_sdc_rst(rst), .i_sdc_enc(enc1), .i_sdc_enc_vld(ev1),
    .o_sdc_enc_rdy(rdy1), .o_sdc_op(op1), .o_sdc_op_vld(ov1), .i_sdc_op_rdy(op_rdy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_t mk_op(input logic [4:0] opc, input logic [1:0] p, input logic [1:0] q,
                                input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                input logic imm, input logic [15:0] iv);
    op_t o;
    o = '0;
    o.opc = opc; o.p = p; o.q = q; o.a = a; o.b = b; o.c = c; o.imm = imm; o.imm_val = iv;
    return o;
  endfunction

  function automatic logic cur_rdy(input int l);
    if (l == 4) return rdy4;
    if (l == 8) return rdy8;
    return rdy1;
  endfunction

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic beat(input int l, input logic [7:0] v);
    int n;
    n = 0;
    if (l == 4) begin enc4 = v[3:0]; ev4 = 1'b1; end
    else if (l == 8) begin enc8 = v; ev8 = 1'b1; end
    else begin enc1 = v[0:0]; ev1 = 1'b1; end
    #1;
    while (!cur_rdy(l) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("enc_rdy_timeout", 64'(cur_rdy(l)), 64'd1);
    @(posedge clk);
    @(negedge clk);
    ev4 = 1'b0; ev8 = 1'b0; ev1 = 1'b0;
  endtask

  op_t e_a, e_b, e_c, e_z, e_e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_rdy = 1'b1;
    enc4 = '0; enc8 = '0; enc1 = '0; ev4 = 1'b0; ev8 = 1'b0; ev1 = 1'b0;
    // 0x01AB: opc 0, p forced PT, q 10, a 110, b 101, c 011
    e_a = mk_op(5'b00000, 2'b11, 2'b10, 3'b110, 3'b101, 3'b011, 1'b0, 16'h0000);
    // 0xC5AF + imm 0x1234
    e_b = mk_op(5'b11000, 2'b10, 2'b10, 3'b110, 3'b101, 3'b111, 1'b1, 16'h1234);
    // 0x4A12: opc 01001, p 01, q 00, a 000, b 010, c 010
    e_c = mk_op(5'b01001, 2'b01, 2'b00, 3'b000, 3'b010, 3'b010, 1'b0, 16'h0000);
    e_z = mk_op(5'b00000, 2'b11, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_vld", 64'(ov4), 64'd0);
    chk("reset_op", 64'(op4), 64'd0);
    chk("reset_enc_rdy", 64'(rdy4), 64'd1);

    // single op, no immediate
    beat(4, 8'h0); beat(4, 8'h1); beat(4, 8'hA);
    chk("l4_vld_before_last", 64'(ov4), 64'd0);
    beat(4, 8'hB);
    chk("l4_vld", 64'(ov4), 64'd1);
    chk("l4_op_01ab", 64'(op4), 64'(e_a));
    @(negedge clk);
    chk("l4_drain", 64'(ov4), 64'd0);

    // insn with immediate, with idle gaps mid-word
    beat(4, 8'hC); beat(4, 8'h5);
    repeat (3) @(negedge clk);
    beat(4, 8'hA); beat(4, 8'hF);
    chk("imm_no_vld_after_insn", 64'(ov4), 64'd0);
    beat(4, 8'h1); beat(4, 8'h2); beat(4, 8'h3);
    chk("imm_no_vld_7", 64'(ov4), 64'd0);
    beat(4, 8'h4);
    chk("imm_vld", 64'(ov4), 64'd1);
    chk("imm_op_c5af", 64'(op4), 64'(e_b));
    @(negedge clk);

    // back-pressure: op held, next insn overlaps until its final beat
    op_rdy = 1'b0;
    beat(4, 8'h0); beat(4, 8'h1); beat(4, 8'hA); beat(4, 8'hB);
    chk("bp_first_vld", 64'(ov4), 64'd1);
    beat(4, 8'h4); beat(4, 8'hA); beat(4, 8'h1);
    chk("bp_held_vld", 64'(ov4), 64'd1);
    chk("bp_held_op", 64'(op4), 64'(e_a));
    enc4 = 4'h2; ev4 = 1'b1;
    #1;
    chk("bp_final_rdy_low", 64'(rdy4), 64'd0);
    @(negedge clk); #1;
    chk("bp_final_rdy_low2", 64'(rdy4), 64'd0);
    chk("bp_still_held", 64'(op4), 64'(e_a));
    op_rdy = 1'b1;
    #1;
    chk("bp_final_rdy_high", 64'(rdy4), 64'd1);
    @(posedge clk);
    @(negedge clk);
    ev4 = 1'b0;
    chk("bp_b2b_vld", 64'(ov4), 64'd1);
    chk("bp_b2b_op", 64'(op4), 64'(e_c));
    @(negedge clk);
    chk("bp_drain", 64'(ov4), 64'd0);

    // reset mid-word discards partial beats
    beat(4, 8'h0); beat(4, 8'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    beat(4, 8'h0); beat(4, 8'h0);
    chk("rst_partial_2", 64'(ov4), 64'd0);
    beat(4, 8'h0);
    chk("rst_partial_3", 64'(ov4), 64'd0);
    beat(4, 8'h0);
    chk("rst_fresh_vld", 64'(ov4), 64'd1);
    chk("rst_fresh_op", 64'(op4), 64'(e_z));
    @(negedge clk);

    // reserved encoding 0x1007
    beat(4, 8'h1); beat(4, 8'h0); beat(4, 8'h0); beat(4, 8'h7);
`ifdef IDLI_SDC_ERR_EN
    e_e = mk_op(5'b00010, 2'b00, 2'b00, 3'b000, 3'b000, 3'b111, 1'b0, 16'h0000);
    e_e.err = 1'b1;
    chk("err_vld", 64'(ov4), 64'd1);
    chk("err_op", 64'(op4), 64'(e_e));
    @(negedge clk);
`else
    e_e = mk_op(5'b00010, 2'b00, 2'b00, 3'b000, 3'b000, 3'b111, 1'b1, 16'h0009);
    chk("noerr_imm_wait", 64'(ov4), 64'd0);
    beat(4, 8'h0); beat(4, 8'h0); beat(4, 8'h0); beat(4, 8'h9);
    chk("noerr_vld", 64'(ov4), 64'd1);
    chk("noerr_op", 64'(op4), 64'(e_e));
    @(negedge clk);
`endif

    // LANES = 8
    beat(8, 8'h01);
    chk("l8_vld_before_last", 64'(ov8), 64'd0);
    beat(8, 8'hAB);
    chk("l8_vld", 64'(ov8), 64'd1);
    chk("l8_op", 64'(op8), 64'(e_a));
    @(negedge clk);

    // LANES = 1, MSB first
    begin
      logic [15:0] w;
      w = 16'h01AB;
      for (int i = 15; i >= 1; i--) beat(1, {7'd0, w[i]});
      chk("l1_vld_before_last", 64'(ov1), 64'd0);
      beat(1, {7'd0, w[0]});
    end
    chk("l1_vld", 64'(ov1), 64'd1);
    chk("l1_op", 64'(op1), 64'(e_a));
    @(negedge clk);
    chk("l1_drain", 64'(ov1), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
